// File: rtl/issue_rollback_ctrl_if.sv
// Issue/rollback handshake bundle between the ID stage, hazard detector and fetch redirect.
// master drives the pipeline-side inputs, slave is the rollback controller.
interface issue_rollback_ctrl_if;
    logic [2:0]  id_valid;
    logic [31:0] id_pc;
    logic [1:0]  rollback;
    logic        ex_take_branch;
    logic [31:0] ex_target_pc;
    logic        mem_busy;
    logic [2:0]  issue_valid;
    logic        if_redirect;
    logic [31:0] if_redirect_pc;
    logic        id_hold;
    logic        stuck_err;

    modport master (
        output id_valid, id_pc, rollback, ex_take_branch, ex_target_pc, mem_busy,
        input  issue_valid, if_redirect, if_redirect_pc, id_hold, stuck_err
    );

    modport slave (
        input  id_valid, id_pc, rollback, ex_take_branch, ex_target_pc, mem_busy,
        output issue_valid, if_redirect, if_redirect_pc, id_hold, stuck_err
    );
endinterface

// File: rtl/issue_rollback_ctrl.sv
// Three-way issue gate with partial rollback, branch flush and livelock detection.
// Optional ROLLBACK_STATS_EN adds saturating rollback_cnt / bubble_cnt outputs.
//
// state  | meaning
// RUN    | normal issue; rollback squashes youngest ways and refetches them
// REPLAY | one bubble cycle after a rollback while fetch restarts
// FLUSH  | one bubble cycle after an EX branch redirect
module issue_rollback_ctrl (
    input  logic                  clock,
    input  logic                  reset,
    issue_rollback_ctrl_if.slave  bus
`ifdef ROLLBACK_STATS_EN
    ,
    output logic [31:0]           rollback_cnt,
    output logic [31:0]           bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_REPLAY = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [1:0]  rb_eff;
    logic [1:0]  ways_kept;
    logic [2:0]  keep_mask;
    logic        rb_act;
    logic        rb3_act;
    logic        same_pc;

    logic [2:0]  issue_valid;
    logic        if_redirect;
    logic [31:0] if_redirect_pc;
    logic        id_hold;

    logic [1:0]  stuck_cnt;
    logic [31:0] last_pc;
    logic        last_valid;
    logic        stuck_err;

    // A rollback against an empty ID bundle has nothing to squash.
    assign rb_eff    = (bus.id_valid == 3'b000) ? 2'd0 : bus.rollback;
    assign ways_kept = 2'd3 - rb_eff;

    always_comb begin
        keep_mask = 3'b111;
        case (rb_eff)
            2'd0:    keep_mask = 3'b111;
            2'd1:    keep_mask = 3'b011;
            2'd2:    keep_mask = 3'b001;
            default: keep_mask = 3'b000;
        endcase
    end

    assign rb_act  = (state == ST_RUN) && !bus.ex_take_branch && !bus.mem_busy
                     && (rb_eff != 2'd0);
    assign rb3_act = rb_act && (rb_eff == 2'd3);
    assign same_pc = last_valid && (last_pc == bus.id_pc);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        if (bus.ex_take_branch) begin
            state_next = ST_FLUSH;
        end else if (bus.mem_busy) begin
            state_next = state;
        end else begin
            case (state)
                ST_RUN:    state_next = (rb_eff != 2'd0) ? ST_REPLAY : ST_RUN;
                ST_REPLAY: state_next = ST_RUN;
                ST_FLUSH:  state_next = ST_RUN;
                default:   state_next = ST_RUN;
            endcase
        end
    end

    // Output logic
    always_comb begin
        issue_valid    = 3'b000;
        if_redirect    = 1'b0;
        if_redirect_pc = 32'd0;
        id_hold        = 1'b0;
        if (reset) begin
            issue_valid    = 3'b000;
        end else if (bus.ex_take_branch) begin
            if_redirect    = 1'b1;
            if_redirect_pc = bus.ex_target_pc;
        end else if (bus.mem_busy) begin
            id_hold        = 1'b1;
        end else if (state == ST_RUN) begin
            issue_valid = bus.id_valid & keep_mask;
            if (rb_eff != 2'd0) begin
                if_redirect    = 1'b1;
                if_redirect_pc = bus.id_pc + {28'd0, ways_kept, 2'b00};
            end
        end
    end

    // Livelock watch: repeated full squashes of the same bundle without progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            stuck_cnt  <= 2'd0;
            last_pc    <= 32'd0;
            last_valid <= 1'b0;
            stuck_err  <= 1'b0;
        end else begin
            if (bus.ex_take_branch || (state == ST_RUN && issue_valid != 3'b000)) begin
                stuck_cnt  <= 2'd0;
                last_valid <= 1'b0;
            end else if (rb3_act) begin
                last_pc    <= bus.id_pc;
                last_valid <= 1'b1;
                if (same_pc) begin
                    if (stuck_cnt != 2'd3) begin
                        stuck_cnt <= stuck_cnt + 2'd1;
                    end
                    if (stuck_cnt >= 2'd2) begin
                        stuck_err <= 1'b1;
                    end
                end else begin
                    stuck_cnt <= 2'd1;
                end
            end
        end
    end

`ifdef ROLLBACK_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            rollback_cnt <= 32'd0;
            bubble_cnt   <= 32'd0;
        end else begin
            if (rb_act && rollback_cnt != 32'hFFFF_FFFF) begin
                rollback_cnt <= rollback_cnt + 32'd1;
            end
            if ((state == ST_REPLAY || state == ST_FLUSH) && bubble_cnt != 32'hFFFF_FFFF) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
        end
    end
`endif

    assign bus.issue_valid    = issue_valid;
    assign bus.if_redirect    = if_redirect;
    assign bus.if_redirect_pc = if_redirect_pc;
    assign bus.id_hold        = id_hold;
    assign bus.stuck_err      = stuck_err;

endmodule

// File: tb/tb_issue_rollback_ctrl.sv
// Directed bench for issue_rollback_ctrl: hand-computed vectors, one cycle per step.
module tb_issue_rollback_ctrl;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    issue_rollback_ctrl_if bus ();

`ifdef ROLLBACK_STATS_EN
    logic [31:0] rollback_cnt;
    logic [31:0] bubble_cnt;
`endif

    issue_rollback_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
`ifdef ROLLBACK_STATS_EN
        ,
        .rollback_cnt (rollback_cnt),
        .bubble_cnt   (bubble_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic [2:0] vld, input logic [31:0] pc, input logic [1:0] rb,
                          input logic br, input logic [31:0] tgt, input logic busy);
        bus.id_valid       = vld;
        bus.id_pc          = pc;
        bus.rollback       = rb;
        bus.ex_take_branch = br;
        bus.ex_target_pc   = tgt;
        bus.mem_busy       = busy;
    endtask

    // Advance to the next cycle's setup point (just after the falling edge).
    task automatic next_cycle();
        @(negedge clock);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        set_in(3'b111, 32'h0000_0100, 2'd1, 1'b1, 32'h0000_0123, 1'b0);
        repeat (2) @(negedge clock);
        #1;
        chk("rst_iv",    {29'd0, bus.issue_valid}, 32'd0);
        chk("rst_redir", {31'd0, bus.if_redirect}, 32'd0);
        chk("rst_pc",    bus.if_redirect_pc,       32'd0);
        chk("rst_hold",  {31'd0, bus.id_hold},     32'd0);
        chk("rst_stuck", {31'd0, bus.stuck_err},   32'd0);

        // Plain issue
        next_cycle(); reset = 1'b0;
        set_in(3'b101, 32'h0000_0040, 2'd0, 1'b0, 32'd0, 1'b0); #1;
        chk("run_iv",    {29'd0, bus.issue_valid}, 32'h5);
        chk("run_redir", {31'd0, bus.if_redirect}, 32'd0);

        // Rollback 1 at 0x100, then REPLAY, then RUN
        next_cycle(); set_in(3'b111, 32'h0000_0100, 2'd1, 1'b0, 32'd0, 1'b0); #1;
        chk("rb1_iv",    {29'd0, bus.issue_valid}, 32'h3);
        chk("rb1_redir", {31'd0, bus.if_redirect}, 32'd1);
        chk("rb1_pc",    bus.if_redirect_pc,       32'h0000_0108);
        next_cycle(); #1;
        chk("replay_iv",    {29'd0, bus.issue_valid}, 32'd0);
        chk("replay_redir", {31'd0, bus.if_redirect}, 32'd0);
        next_cycle(); set_in(3'b111, 32'h0000_010C, 2'd0, 1'b0, 32'd0, 1'b0); #1;
        chk("after_replay_iv", {29'd0, bus.issue_valid}, 32'h7);

        // Rollback 2 under memory stall, then released
        next_cycle(); set_in(3'b111, 32'h0000_0300, 2'd2, 1'b0, 32'd0, 1'b1); #1;
        chk("busy_iv",    {29'd0, bus.issue_valid}, 32'd0);
        chk("busy_hold",  {31'd0, bus.id_hold},     32'd1);
        chk("busy_redir", {31'd0, bus.if_redirect}, 32'd0);
        next_cycle(); bus.mem_busy = 1'b0; #1;
        chk("rb2_iv",    {29'd0, bus.issue_valid}, 32'h1);
        chk("rb2_redir", {31'd0, bus.if_redirect}, 32'd1);
        chk("rb2_pc",    bus.if_redirect_pc,       32'h0000_0304);
        chk("rb2_hold",  {31'd0, bus.id_hold},     32'd0);

        // Branch during REPLAY -> FLUSH -> RUN
        next_cycle(); set_in(3'b111, 32'h0000_0304, 2'd0, 1'b1, 32'h0000_0400, 1'b0); #1;
        chk("br_redir", {31'd0, bus.if_redirect}, 32'd1);
        chk("br_pc",    bus.if_redirect_pc,       32'h0000_0400);
        chk("br_iv",    {29'd0, bus.issue_valid}, 32'd0);
        next_cycle(); set_in(3'b111, 32'h0000_0400, 2'd1, 1'b0, 32'd0, 1'b0); #1;
        chk("flush_iv",    {29'd0, bus.issue_valid}, 32'd0);
        chk("flush_redir", {31'd0, bus.if_redirect}, 32'd0);
        next_cycle(); set_in(3'b111, 32'h0000_0400, 2'd0, 1'b0, 32'd0, 1'b0); #1;
        chk("post_flush_iv", {29'd0, bus.issue_valid}, 32'h7);

        // PC wrap on rollback
        next_cycle(); set_in(3'b111, 32'hFFFF_FFFC, 2'd1, 1'b0, 32'd0, 1'b0); #1;
        chk("wrap_pc", bus.if_redirect_pc, 32'h0000_0004);
        next_cycle(); set_in(3'b000, 32'd0, 2'd0, 1'b0, 32'd0, 1'b0); #1;
        chk("wrap_replay_iv", {29'd0, bus.issue_valid}, 32'd0);

        // Rollback against an empty bundle is ignored
        next_cycle(); set_in(3'b000, 32'h0000_0500, 2'd3, 1'b0, 32'd0, 1'b0); #1;
        chk("empty_redir", {31'd0, bus.if_redirect}, 32'd0);
        next_cycle(); set_in(3'b110, 32'h0000_0500, 2'd0, 1'b0, 32'd0, 1'b0); #1;
        chk("empty_next_iv", {29'd0, bus.issue_valid}, 32'h6);

        // Livelock: three full squashes at the same PC
        for (int i = 0; i < 3; i++) begin
            next_cycle(); set_in(3'b111, 32'h0000_0200, 2'd3, 1'b0, 32'd0, 1'b0); #1;
            chk("rb3_iv",    {29'd0, bus.issue_valid}, 32'd0);
            chk("rb3_pc",    bus.if_redirect_pc,       32'h0000_0200);
            chk("rb3_stuck", {31'd0, bus.stuck_err},   32'd0);
            next_cycle(); #1;
            chk("rb3_replay_stuck", {31'd0, bus.stuck_err}, (i == 2) ? 32'd1 : 32'd0);
        end
        next_cycle(); set_in(3'b111, 32'h0000_0200, 2'd0, 1'b0, 32'd0, 1'b0); #1;
        chk("stuck_iv", {29'd0, bus.issue_valid}, 32'h7);
        next_cycle(); #1;
        chk("stuck_hold_on", {31'd0, bus.stuck_err}, 32'd1);

        // Reset during FLUSH
        next_cycle(); set_in(3'b111, 32'h0000_0600, 2'd0, 1'b1, 32'h0000_0700, 1'b0); #1;
        chk("br2_redir", {31'd0, bus.if_redirect}, 32'd1);
`ifdef ROLLBACK_STATS_EN
        chk("stats_rb_nonzero", {31'd0, (rollback_cnt != 32'd0)}, 32'd1);
        chk("stats_bub_nonzero", {31'd0, (bubble_cnt != 32'd0)}, 32'd1);
`endif
        next_cycle(); reset = 1'b1;
        set_in(3'b111, 32'h0000_0700, 2'd1, 1'b1, 32'h0000_0123, 1'b1); #1;
        chk("rst2_iv",    {29'd0, bus.issue_valid}, 32'd0);
        chk("rst2_redir", {31'd0, bus.if_redirect}, 32'd0);
        chk("rst2_pc",    bus.if_redirect_pc,       32'd0);
        chk("rst2_hold",  {31'd0, bus.id_hold},     32'd0);
        next_cycle(); reset = 1'b0;
        set_in(3'b111, 32'h0000_0700, 2'd0, 1'b0, 32'd0, 1'b0); #1;
        chk("post_rst_iv",    {29'd0, bus.issue_valid}, 32'h7);
        chk("post_rst_stuck", {31'd0, bus.stuck_err},   32'd0);
`ifdef ROLLBACK_STATS_EN
        chk("stats_rb_clr",  rollback_cnt, 32'd0);
        chk("stats_bub_clr", bubble_cnt,   32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/issue_rollback_ctrl.md
ISSUE_ROLLBACK_CTRL -- requirements
Module: issue_rollback_ctrl

Interface
REQ-001 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port id_valid  input  3  valid bit per ID way (bit i = way i).
REQ-004 SHALL have port id_pc  input  32  PC of ID way 0; way i PC = id_pc + 4*i.
REQ-005 SHALL have port rollback  input  2  hazard-detector count of youngest ways to squash (0..3).
REQ-006 SHALL have port ex_take_branch  input  1  EX resolved taken/mispredicted branch.
REQ-007 SHALL have port ex_target_pc  input  32  redirect target for ex_take_branch.
REQ-008 SHALL have port mem_busy  input  1  memory structural stall; whole front end holds.
REQ-009 SHALL have port issue_valid  output  3  ways allowed to advance ID->EX this cycle.
REQ-010 SHALL have port if_redirect  output  1  fetch PC override this cycle.
REQ-011 SHALL have port if_redirect_pc  output  32  override PC, valid when if_redirect=1.
REQ-012 SHALL have port id_hold  output  1  ID/IF registers keep contents this cycle.
REQ-013 SHALL have port stuck_err  output  1  sticky livelock flag.

Function
REQ-014 SHALL implement FSM states RUN, REPLAY, FLUSH; outputs combinational from state and inputs.
REQ-015 Priority in every state SHALL be: ex_take_branch > mem_busy > state action > rollback.
REQ-016 ex_take_branch=1 (any state): issue_valid=000, if_redirect=1, if_redirect_pc=ex_target_pc, id_hold=0, next FLUSH.
REQ-017 mem_busy=1 (no branch): issue_valid=000, if_redirect=0, id_hold=1, state unchanged.
REQ-018 RUN, rollback=0: issue_valid=id_valid, if_redirect=0, next RUN.
REQ-019 RUN, rollback=r>0: issue_valid=id_valid & mask (r=1:011, r=2:001, r=3:000), if_redirect=1, if_redirect_pc=id_pc+4*(3-r) mod 2^32.
REQ-020 RUN, rollback>0: next state REPLAY.
REQ-021 REPLAY: one cycle, issue_valid=000, if_redirect=0, rollback ignored, next RUN.
REQ-022 FLUSH: one cycle, issue_valid=000, if_redirect=0, rollback ignored, next RUN.
REQ-023 Rollback with id_valid=000 SHALL be treated as rollback=0.
REQ-024 2-bit saturating counter SHALL increment on each RUN rollback=3 with same id_pc as previous rollback=3, clear on any RUN cycle issuing a valid way or on branch.
REQ-025 stuck_err SHALL set when counter reaches 3 and hold until reset.

Reset
REQ-026 reset=1 SHALL force state RUN, counter 0, stuck_err 0, stats 0.
REQ-027 While reset=1, issue_valid=000, if_redirect=0, if_redirect_pc=0, id_hold=0 regardless of inputs.
REQ-028 Reset asserted mid-REPLAY/FLUSH SHALL abandon it; first post-reset cycle is RUN.

Configuration
REQ-029 Macro ROLLBACK_STATS_EN SHALL, when defined, add outputs rollback_cnt[31:0] and bubble_cnt[31:0].
REQ-030 With ROLLBACK_STATS_EN: rollback_cnt +1 per RUN rollback>0 cycle; bubble_cnt +1 per REPLAY/FLUSH cycle; both saturate at 32'hFFFF_FFFF.
REQ-031 Without ROLLBACK_STATS_EN: ports and counters absent; all other behaviour identical.

Verification
REQ-032 RUN, id_valid=111, id_pc=0x100, rollback=1 -> issue_valid=011, redirect 0x108; next cycle REPLAY issue_valid=000; then RUN.
REQ-033 RUN, rollback=3, id_pc=0x200 -> issue_valid=000, redirect 0x200; repeated 3x same PC -> stuck_err=1 and stays 1.
REQ-034 REPLAY with ex_take_branch=1, ex_target_pc=0x400 -> redirect 0x400, issue_valid=000, next FLUSH, then RUN.
REQ-035 RUN, rollback=2, mem_busy=1 -> issue_valid=000, id_hold=1, if_redirect=0, state RUN; mem_busy drops -> issue_valid=001, redirect id_pc+4.
REQ-036 id_pc=0xFFFF_FFFC, rollback=1 -> if_redirect_pc=0x0000_0004 (wrap).
REQ-037 reset pulse during FLUSH with ROLLBACK_STATS_EN, counters nonzero -> counters 0, outputs idle, next cycle RUN.
